// File: rtl/cp0_if.sv
// -----------------------------------------------------------------------------
// cp0_if
// Purpose : Groups the M-stage pipeline signals that feed Coprocessor-0.
//           It also groups the CP0 results that go back to the pipeline.
// Modports:
//   master  pipeline side: drives mfc0/mtc0, M-stage PC/BD/exccode,
//           hwint and eret; receives req, epc_out and cp0_rdata.
//   slave   CP0 side: the mirror of master.
// Signals :
//   cp0_raddr[4:0]  mfc0 register index
//   cp0_waddr[4:0]  mtc0 register index
//   cp0_wdata[31:0] mtc0 write data
//   cp0_we          mtc0 write enable
//   pcM[31:0]       PC of the M-stage instruction
//   bdM             M-stage instruction sits in a branch delay slot
//   exccodeM[4:0]   pending exception code, 0 = none
//   hwint[5:0]      level-sensitive external interrupts
//   eretM           eret in M
//   req             exception/interrupt taken this cycle
//   epc_out[31:0]   current EPC register
//   cp0_rdata[31:0] mfc0 read data
// -----------------------------------------------------------------------------
interface cp0_if;
    logic [4:0]  cp0_raddr;
    logic [4:0]  cp0_waddr;
    logic [31:0] cp0_wdata;
    logic        cp0_we;
    logic [31:0] pcM;
    logic        bdM;
    logic [4:0]  exccodeM;
    logic [5:0]  hwint;
    logic        eretM;
    logic        req;
    logic [31:0] epc_out;
    logic [31:0] cp0_rdata;

    modport master (
        output cp0_raddr, cp0_waddr, cp0_wdata, cp0_we,
        output pcM, bdM, exccodeM, hwint, eretM,
        input  req, epc_out, cp0_rdata
    );

    modport slave (
        input  cp0_raddr, cp0_waddr, cp0_wdata, cp0_we,
        input  pcM, bdM, exccodeM, hwint, eretM,
        output req, epc_out, cp0_rdata
    );
endinterface

// File: rtl/cp0_unit.sv
// -----------------------------------------------------------------------------
// cp0_unit
// Purpose : Coprocessor-0 for the 5-stage MIPS pipeline, sitting in M.
//           - Owns SR(12), Cause(13), EPC(14) and PRId(15).
//           - Decides exception/interrupt entry (o req flushes the pipe).
//           - Supplies EPC for eret redirection.
// Ports   :
//   i_clk    system clock, all state on posedge
//   i_reset  synchronous active-high reset
//   io_cp0   cp0_if.slave bundle:
//            mfc0/mtc0 access, M-stage PC/BD/exccode, hwint, eret in;
//            req/epc_out/cp0_rdata out
// Config  : define CP0_TIMER_EN to add Count(9)/Compare(11) and the timer
//           interrupt TI, which is ORed into hwint line 5.
//           When undefined, regs 9/11 read 0 and TI reads 0.
// -----------------------------------------------------------------------------
module cp0_unit #(
    parameter logic [31:0] PRID      = 32'h4D49_5053,
    parameter logic [31:0] EPC_RESET = 32'h0000_3000
) (
    input  logic  i_clk,
    input  logic  i_reset,
    cp0_if.slave  io_cp0
);

    logic [5:0]  r_im;
    logic        r_exl;
    logic        r_ie;
    logic        r_bd;
    logic [4:0]  r_exccode;
    logic [5:0]  r_ip;
    logic [31:0] r_epc;

    logic [5:0]  w_hwint_eff;
    logic        w_int_req;
    logic        w_exc_req;
    logic        w_req;
    logic        w_wr;
    logic        w_ti;
    logic [31:0] w_epc_pc;

`ifdef CP0_TIMER_EN
    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic        r_ti;

    assign w_ti = r_ti;
`else
    assign w_ti = 1'b0;
`endif

    assign w_hwint_eff = {io_cp0.hwint[5] | w_ti, io_cp0.hwint[4:0]};
    assign w_int_req   = (|(w_hwint_eff & r_im)) & r_ie & ~r_exl;
    assign w_exc_req   = (io_cp0.exccodeM != 5'd0) & ~r_exl;
    assign w_req       = w_int_req | w_exc_req;

    // mtc0 loses to both exception entry and eret on the same edge.
    assign w_wr = io_cp0.cp0_we & ~w_req & ~io_cp0.eretM;

    // Delay-slot instructions restart at the branch.
    // The subtraction wraps modulo 2^32.
    assign w_epc_pc = io_cp0.bdM ? (io_cp0.pcM - 32'd4) : io_cp0.pcM;

    assign io_cp0.req     = w_req;
    assign io_cp0.epc_out = r_epc;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_im      <= 6'd0;
            r_exl     <= 1'b0;
            r_ie      <= 1'b0;
            r_bd      <= 1'b0;
            r_exccode <= 5'd0;
            r_ip      <= 6'd0;
            r_epc     <= EPC_RESET;
        end else begin
            r_ip <= w_hwint_eff;
            if (w_req) begin
                r_exl     <= 1'b1;
                r_bd      <= io_cp0.bdM;
                // Interrupts take priority over a simultaneous exception.
                r_exccode <= w_int_req ? 5'd0 : io_cp0.exccodeM;
                r_epc     <= {w_epc_pc[31:2], 2'b00};
            end else if (io_cp0.eretM) begin
                r_exl <= 1'b0;
            end else if (w_wr) begin
                case (io_cp0.cp0_waddr)
                    5'd12: begin
                        r_im  <= io_cp0.cp0_wdata[15:10];
                        r_exl <= io_cp0.cp0_wdata[1];
                        r_ie  <= io_cp0.cp0_wdata[0];
                    end
                    5'd14: r_epc <= {io_cp0.cp0_wdata[31:2], 2'b00};
                    default: ;
                endcase
            end
        end
    end

`ifdef CP0_TIMER_EN
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_count   <= 32'd0;
            r_compare <= 32'hFFFF_FFFF;
            r_ti      <= 1'b0;
        end else begin
            // A software write to Count replaces this cycle's increment.
            if (w_wr && io_cp0.cp0_waddr == 5'd9)
                r_count <= io_cp0.cp0_wdata;
            else
                r_count <= r_count + 32'd1;

            // Writing Compare acknowledges the timer; otherwise TI is sticky.
            if (w_wr && io_cp0.cp0_waddr == 5'd11) begin
                r_compare <= io_cp0.cp0_wdata;
                r_ti      <= 1'b0;
            end else if (r_count == r_compare) begin
                r_ti <= 1'b1;
            end
        end
    end
`endif

    // Reads see current register state; same-cycle writes are not forwarded.
    always_comb begin
        io_cp0.cp0_rdata = 32'd0;
        case (io_cp0.cp0_raddr)
            5'd12: io_cp0.cp0_rdata = {16'd0, r_im, 8'd0, r_exl, r_ie};
            5'd13: io_cp0.cp0_rdata = {r_bd, w_ti, 14'd0, r_ip, 3'd0, r_exccode, 2'd0};
            5'd14: io_cp0.cp0_rdata = r_epc;
            5'd15: io_cp0.cp0_rdata = PRID;
`ifdef CP0_TIMER_EN
            5'd9:  io_cp0.cp0_rdata = r_count;
            5'd11: io_cp0.cp0_rdata = r_compare;
`endif
            default: io_cp0.cp0_rdata = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_cp0_unit.sv
// -----------------------------------------------------------------------------
// tb_cp0_unit
// Directed stimulus for cp0_unit with a queue-based scoreboard.
// The stimulus side drives inputs just after each posedge.
// In the same cycle it queues the values it expects to see.
// A monitor on the following negedge pops the queue and compares.
// -----------------------------------------------------------------------------
module tb_cp0_unit;

    localparam logic [31:0] PRID = 32'h4D49_5053;

    logic clk = 1'b0;
    logic reset;

    cp0_if bus ();

    cp0_unit dut (
        .i_clk   (clk),
        .i_reset (reset),
        .io_cp0  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          sel;    // 0 = cp0_rdata, 1 = req, 2 = epc_out
        logic [31:0] exp;
    } exp_t;

    exp_t        q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    exp_t        m_e;
    logic [31:0] m_act;

    always @(negedge clk) begin
        while (q.size() > 0) begin
            m_e = q.pop_front();
            case (m_e.sel)
                0:       m_act = bus.cp0_rdata;
                1:       m_act = {31'd0, bus.req};
                default: m_act = bus.epc_out;
            endcase
            n_cmp++;
            if (m_act !== m_e.exp) begin
                n_bad++;
                $display("FAIL %s: got %h, expected %h", m_e.name, m_act, m_e.exp);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string name, input int sel, input logic [31:0] exp);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.exp  = exp;
        q.push_back(e);
    endtask

    task automatic chk_req(input logic v, input string name);
        push(name, 1, {31'd0, v});
    endtask

    // Reads one register this cycle, then advances one clock.
    task automatic rd(input logic [4:0] a, input logic [31:0] v, input string name);
        bus.cp0_raddr = a;
        push(name, 0, v);
        cyc();
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        bus.cp0_we    = 1'b1;
        bus.cp0_waddr = a;
        bus.cp0_wdata = d;
        cyc();
        bus.cp0_we    = 1'b0;
    endtask

    initial begin
        reset         = 1'b1;
        bus.cp0_raddr = 5'd0;
        bus.cp0_waddr = 5'd0;
        bus.cp0_wdata = 32'd0;
        bus.cp0_we    = 1'b0;
        bus.pcM       = 32'd0;
        bus.bdM       = 1'b0;
        bus.exccodeM  = 5'd0;
        bus.hwint     = 6'd0;
        bus.eretM     = 1'b0;
        repeat (3) cyc();
        reset = 1'b0;

        // Reset state
        chk_req(1'b0, "reset_req");
        rd(5'd12, 32'd0, "reset_sr");
        rd(5'd13, 32'd0, "reset_cause");
        push("reset_epc_out", 2, 32'h0000_3000);
        rd(5'd14, 32'h0000_3000, "reset_epc");
        rd(5'd15, PRID, "prid");
        rd(5'd0, 32'd0, "unimpl_reg0");

        // Enable IM[0] and IE, then raise hwint[0]
        mtc0(5'd12, 32'h0000_0401);
        chk_req(1'b0, "sr_written_no_int");
        rd(5'd12, 32'h0000_0401, "sr_readback");
        bus.hwint = 6'b000001;
        bus.pcM   = 32'h0000_3040;
        chk_req(1'b1, "int_req");
        rd(5'd13, 32'd0, "cause_before_entry");
        chk_req(1'b0, "int_masked_by_exl");
        rd(5'd12, 32'h0000_0403, "sr_exl_set");
        rd(5'd13, 32'h0000_0400, "cause_int_ip");
        push("epc_out_int", 2, 32'h0000_3040);
        rd(5'd14, 32'h0000_3040, "epc_int");

        // Exception in a delay slot
        bus.hwint = 6'd0;
        bus.eretM = 1'b1;
        chk_req(1'b0, "eret_no_req");
        cyc();
        bus.eretM    = 1'b0;
        bus.exccodeM = 5'd4;
        bus.bdM      = 1'b1;
        bus.pcM      = 32'h0000_3010;
        chk_req(1'b1, "exc_req");
        cyc();
        bus.exccodeM = 5'd0;
        bus.bdM      = 1'b0;
        rd(5'd13, 32'h8000_0010, "cause_bd_exc4");
        rd(5'd14, 32'h0000_300C, "epc_bd");
        rd(5'd12, 32'h0000_0403, "sr_after_exc");

        // Exception entry beats a coinciding mtc0 to EPC
        bus.eretM = 1'b1;
        cyc();
        bus.eretM     = 1'b0;
        bus.exccodeM  = 5'd8;
        bus.pcM       = 32'h0000_3020;
        bus.cp0_we    = 1'b1;
        bus.cp0_waddr = 5'd14;
        bus.cp0_wdata = 32'h0000_1234;
        chk_req(1'b1, "exc_with_mtc0");
        cyc();
        bus.cp0_we   = 1'b0;
        bus.exccodeM = 5'd0;
        rd(5'd14, 32'h0000_3020, "epc_not_overwritten");
        rd(5'd13, 32'h0000_0020, "cause_exc8");

        // eret with a held, masked-in interrupt fires the cycle after
        bus.hwint = 6'b000001;
        bus.eretM = 1'b1;
        chk_req(1'b0, "eret_cycle_no_req");
        cyc();
        bus.eretM = 1'b0;
        bus.pcM   = 32'h0000_3050;
        chk_req(1'b1, "int_after_eret");
        cyc();
        rd(5'd13, 32'h0000_0400, "cause_int_after_eret");
        rd(5'd14, 32'h0000_3050, "epc_int_after_eret");

        // mtc0 EPC: no same-cycle forwarding, low bits forced to 0
        bus.hwint     = 6'd0;
        bus.cp0_we    = 1'b1;
        bus.cp0_waddr = 5'd14;
        bus.cp0_wdata = 32'h0000_1237;
        rd(5'd14, 32'h0000_3050, "epc_no_forward");
        bus.cp0_we = 1'b0;
        rd(5'd14, 32'h0000_1234, "epc_mtc0_aligned");

        // Cause and PRId are read-only
        mtc0(5'd13, 32'hFFFF_FFFF);
        rd(5'd13, 32'd0, "cause_write_ignored");
        mtc0(5'd15, 32'd0);
        rd(5'd15, PRID, "prid_write_ignored");

        // pcM = 0 in a delay slot wraps
        bus.eretM = 1'b1;
        cyc();
        bus.eretM    = 1'b0;
        bus.exccodeM = 5'd4;
        bus.bdM      = 1'b1;
        bus.pcM      = 32'd0;
        chk_req(1'b1, "exc_wrap_req");
        cyc();
        bus.exccodeM = 5'd0;
        bus.bdM      = 1'b0;
        rd(5'd14, 32'hFFFF_FFFC, "epc_wrap");

        // Unimplemented SR bits read 0
        mtc0(5'd12, 32'hFFFF_FFFF);
        rd(5'd12, 32'h0000_FC03, "sr_unimpl_bits");

        // All interrupts masked by IM
        mtc0(5'd12, 32'h0000_0001);
        bus.hwint = 6'h3F;
        chk_req(1'b0, "int_masked_by_im");
        rd(5'd0, 32'd0, "unimpl_reg0_again");

        // Interrupt and exception together: ExcCode records the interrupt
        mtc0(5'd12, 32'h0000_0401);
        bus.exccodeM = 5'd4;
        bus.pcM      = 32'h0000_3060;
        chk_req(1'b1, "int_and_exc_req");
        cyc();
        bus.exccodeM = 5'd0;
        rd(5'd13, 32'h0000_FC00, "cause_int_priority");
        rd(5'd14, 32'h0000_3060, "epc_int_priority");

        bus.hwint = 6'd0;
        bus.eretM = 1'b1;
        cyc();
        bus.eretM = 1'b0;

`ifdef CP0_TIMER_EN
        mtc0(5'd12, 32'h0000_8001);
        mtc0(5'd11, 32'd5);
        mtc0(5'd9, 32'd0);
        for (int i = 0; i < 6; i++) begin
            chk_req(1'b0, "timer_not_yet");
            rd(5'd9, i, "count_value");
        end
        chk_req(1'b1, "timer_req");
        rd(5'd13, 32'h4000_0000, "cause_ti_set");
        bus.cp0_we    = 1'b1;
        bus.cp0_waddr = 5'd11;
        bus.cp0_wdata = 32'd100;
        rd(5'd9, 32'd7, "count_during_compare_wr");
        bus.cp0_we = 1'b0;
        rd(5'd13, 32'h0000_8000, "cause_ti_cleared");
        rd(5'd11, 32'd100, "compare_readback");
`else
        mtc0(5'd9, 32'h0000_0055);
        rd(5'd9, 32'd0, "count_absent");
        mtc0(5'd11, 32'd5);
        rd(5'd11, 32'd0, "compare_absent");
`endif

        cyc();
        cyc();
        if (q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
